// File: rtl/intctrl_pkg.sv
// Shared definitions for the intctrl priority interrupt controller:
// register map, status bit positions, FSM states and the priority encoder.
package intctrl_pkg;

    localparam int unsigned MAX_SRC = 8;

    localparam logic [1:0] REG_EN   = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_MODE = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    localparam int unsigned STAT_INSVC_BIT = 31;
    localparam int unsigned STAT_SPUR_BIT  = 8;
    localparam int unsigned STAT_SRC_LSB   = 16;
    localparam int unsigned STAT_SRC_MSB   = 23;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    // Lowest set index wins; returns 0 for an all-zero vector.
    function automatic logic [2:0] prio_enc(input logic [MAX_SRC-1:0] v);
        logic [2:0] enc;
        logic       found;
        enc   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            if (v[i] && !found) begin
                enc   = 3'(i);
                found = 1'b1;
            end
        end
        return enc;
    endfunction

endpackage

// File: rtl/intc_sync_edge.sv
// Per-bit two-flop synchroniser followed by a rising-edge detector.
module intc_sync_edge #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] ff1_q;
    logic [WIDTH-1:0] ff2_q;
    logic [WIDTH-1:0] ff3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_q <= '0;
            ff2_q <= '0;
            ff3_q <= '0;
        end else begin
            ff1_q <= async_i;
            ff2_q <= ff1_q;
            ff3_q <= ff2_q;
        end
    end

    assign level_o = ff2_q;
    assign rise_o  = ff2_q & ~ff3_q;

endmodule

// File: rtl/intctrl.sv
// Priority interrupt controller: sequences the CPU irq among num_src sources
// with an intack/rti handshake and a four-register IO bus interface.
module intctrl
    import intctrl_pkg::*;
#(
    parameter int unsigned num_src = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stb,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    output logic               ack,
    input  logic [num_src-1:0] src,
    input  logic               intack,
    input  logic               rti,
    output logic               irq,
    output logic               in_service,
    output logic [2:0]         cur_src
);

    logic [num_src-1:0] en_q, en_d;
    logic [num_src-1:0] mode_q, mode_d;
    logic [num_src-1:0] pend_q, pend_d;
    logic [num_src-1:0] sync_lvl, rise;
    logic [num_src-1:0] pend_view, req, w1c, trig, ack_clr;
    logic [MAX_SRC-1:0] req8;
    logic [2:0]         enc, cur_q, cur_d;
    logic               any_req, irq_q, irq_d, spur_q, spur_d, take, wr;
    logic [31:0]        rdata;
    logic               unused_data;
    state_t             state_q, state_d;

    intc_sync_edge #(.WIDTH(num_src)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (src),
        .level_o (sync_lvl),
        .rise_o  (rise)
    );

    assign wr          = stb & we;
    assign unused_data = ^data_in[31:num_src];

    // Level-mode bits expose the synchronised input directly; pend_q holds edge bits only.
    assign pend_view = (pend_q & ~mode_q) | (sync_lvl & mode_q);
    assign req       = pend_view & en_q;
    assign any_req   = |req;

    always_comb begin
        req8              = '0;
        req8[num_src-1:0] = req;
        enc               = prio_enc(req8);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (intack) state_d = ST_SERVICE;
            ST_SERVICE: if (rti)    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output / handshake logic
    always_comb begin
        irq_d  = 1'b0;
        cur_d  = cur_q;
        spur_d = spur_q;
        take   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (intack) begin
                take   = 1'b1;
                cur_d  = enc;
                spur_d = ~any_req;
            end else begin
                irq_d = any_req;
            end
        end
    end

    always_comb begin
        en_d    = en_q;
        mode_d  = mode_q;
        w1c     = '0;
        trig    = '0;
        ack_clr = '0;
        if (wr) begin
            case (addr)
                REG_EN:   en_d   = data_in[num_src-1:0];
                REG_PEND: w1c    = data_in[num_src-1:0];
                REG_MODE: mode_d = data_in[num_src-1:0];
                REG_STAT: trig   = data_in[num_src-1:0];
                default:  ;
            endcase
        end
        for (int unsigned i = 0; i < num_src; i++) begin
            if (take && any_req && (enc == 3'(i))) ack_clr[i] = 1'b1;
        end
        pend_d = ((pend_q & ~(w1c | ack_clr)) | rise | trig) & ~mode_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= '0;
            mode_q <= '0;
            pend_q <= '0;
            irq_q  <= 1'b0;
            cur_q  <= '0;
            spur_q <= 1'b0;
        end else begin
            en_q   <= en_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            irq_q  <= irq_d;
            cur_q  <= cur_d;
            spur_q <= spur_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_EN:   rdata[num_src-1:0] = en_q;
            REG_PEND: rdata[num_src-1:0] = pend_view;
            REG_MODE: rdata[num_src-1:0] = mode_q;
            REG_STAT: begin
                rdata[STAT_INSVC_BIT]            = (state_q == ST_SERVICE);
                rdata[STAT_SPUR_BIT]             = spur_q;
                rdata[2:0]                       = cur_q;
                rdata[STAT_SRC_LSB +: num_src]   = sync_lvl;
            end
            default:  rdata = '0;
        endcase
    end

    assign data_out   = stb ? rdata : '0;
    assign ack        = stb;
    assign irq        = irq_q;
    assign in_service = (state_q == ST_SERVICE);
    assign cur_src    = cur_q;

endmodule

// File: tb/tb_intctrl.sv
// Directed self-checking bench for intctrl (num_src = 8).
module tb_intctrl;

    logic        clk = 1'b0;
    logic        rst, stb, we, intack, rti;
    logic [1:0]  addr;
    logic [31:0] data_in, data_out, rd;
    logic        ack, irq, in_service;
    logic [7:0]  src;
    logic [2:0]  cur_src;
    int          tests = 0;
    int          fails = 0;

    always #10 clk = ~clk;

    intctrl #(.num_src(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .stb        (stb),
        .we         (we),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .ack        (ack),
        .src        (src),
        .intack     (intack),
        .rti        (rti),
        .irq        (irq),
        .in_service (in_service),
        .cur_src    (cur_src)
    );

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr = a; data_in = d; stb = 1'b1; we = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0; we = 1'b0; data_in = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        addr = a; stb = 1'b1; we = 1'b0;
        #1;
        d = data_out;
        stb = 1'b0;
    endtask

    task automatic pulse_intack();
        intack = 1'b1;
        @(posedge clk);
        #1;
        intack = 1'b0;
    endtask

    task automatic pulse_rti();
        rti = 1'b1;
        @(posedge clk);
        #1;
        rti = 1'b0;
    endtask

    task automatic test_reset();
        bus_write(2'd0, 32'h01);
        bus_write(2'd3, 32'h01);
        cycles(1);
        pulse_intack();
        tests++; if (in_service !== 1'b1) begin fails++; $display("FAIL rst_pre_svc: got %0b want 1", in_service); end
        #5 rst = 1'b1;
        #1;
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_irq: got %0b want 0", irq); end
        tests++; if (in_service !== 1'b0) begin fails++; $display("FAIL rst_insvc: got %0b want 0", in_service); end
        bus_read(2'd0, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rst_en: got %h want 0", rd); end
        bus_read(2'd1, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rst_pend: got %h want 0", rd); end
        bus_read(2'd2, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rst_mode: got %h want 0", rd); end
        bus_read(2'd3, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rst_stat: got %h want 0", rd); end
        #1 rst = 1'b0;
        cycles(1);
    endtask

    task automatic test_readback();
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd2, 32'h0000_000F);
        bus_read(2'd0, rd);
        tests++; if (rd !== 32'h0000_00FF) begin fails++; $display("FAIL rb_en: got %h want 000000ff", rd); end
        bus_read(2'd2, rd);
        tests++; if (rd !== 32'h0000_000F) begin fails++; $display("FAIL rb_mode: got %h want 0000000f", rd); end
        stb = 1'b1; addr = 2'd0; #1;
        tests++; if (ack !== 1'b1) begin fails++; $display("FAIL rb_ack: got %0b want 1", ack); end
        stb = 1'b0; #1;
        tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL rb_idle_bus: got %h want 0", data_out); end
        bus_write(2'd0, 32'h0);
        bus_write(2'd2, 32'h0);
    endtask

    task automatic test_edge();
        bus_write(2'd0, 32'h04);
        src = 8'h04;
        cycles(1);
        src = 8'h00;
        cycles(2);
        bus_read(2'd1, rd);
        tests++; if (rd !== 32'h04) begin fails++; $display("FAIL edge_pend: got %h want 04", rd); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL edge_irq_early: got %0b want 0", irq); end
        cycles(1);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL edge_irq: got %0b want 1", irq); end
        pulse_intack();
        tests++; if (cur_src !== 3'd2) begin fails++; $display("FAIL edge_cur: got %0d want 2", cur_src); end
        tests++; if (in_service !== 1'b1) begin fails++; $display("FAIL edge_insvc: got %0b want 1", in_service); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL edge_irq_svc: got %0b want 0", irq); end
        bus_read(2'd1, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL edge_pend_clr: got %h want 0", rd); end
        pulse_rti();
        cycles(1);
        tests++; if (in_service !== 1'b0) begin fails++; $display("FAIL edge_rti: got %0b want 0", in_service); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL edge_irq_after: got %0b want 0", irq); end
        bus_write(2'd0, 32'h0);
    endtask

    task automatic test_priority();
        bus_write(2'd0, 32'hFF);
        src = 8'h22;
        cycles(4);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL pri_irq: got %0b want 1", irq); end
        bus_read(2'd3, rd);
        tests++; if (rd[23:16] !== 8'h22) begin fails++; $display("FAIL pri_sync: got %h want 22", rd[23:16]); end
        pulse_intack();
        tests++; if (cur_src !== 3'd1) begin fails++; $display("FAIL pri_cur1: got %0d want 1", cur_src); end
        bus_read(2'd1, rd);
        tests++; if (rd !== 32'h20) begin fails++; $display("FAIL pri_pend: got %h want 20", rd); end
        pulse_rti();
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL pri_irq_rti: got %0b want 0", irq); end
        cycles(1);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL pri_irq_again: got %0b want 1", irq); end
        pulse_intack();
        tests++; if (cur_src !== 3'd5) begin fails++; $display("FAIL pri_cur5: got %0d want 5", cur_src); end
        pulse_rti();
        src = 8'h00;
        bus_write(2'd0, 32'h0);
        cycles(3);
    endtask

    task automatic test_level();
        bus_write(2'd2, 32'h01);
        bus_write(2'd0, 32'h01);
        src = 8'h01;
        cycles(4);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL lvl_irq: got %0b want 1", irq); end
        pulse_intack();
        tests++; if (cur_src !== 3'd0) begin fails++; $display("FAIL lvl_cur: got %0d want 0", cur_src); end
        bus_read(2'd3, rd);
        tests++; if (rd[8] !== 1'b0) begin fails++; $display("FAIL lvl_spur: got %0b want 0", rd[8]); end
        pulse_rti();
        cycles(1);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL lvl_reassert: got %0b want 1", irq); end
        bus_write(2'd1, 32'h01);
        bus_read(2'd1, rd);
        tests++; if (rd !== 32'h01) begin fails++; $display("FAIL lvl_w1c: got %h want 01", rd); end
        src = 8'h00;
        cycles(4);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL lvl_drop: got %0b want 0", irq); end
        bus_read(2'd1, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL lvl_pend_drop: got %h want 0", rd); end
        bus_write(2'd2, 32'h0);
        bus_write(2'd0, 32'h0);
    endtask

    task automatic test_races();
        bus_write(2'd0, 32'h08);
        src = 8'h08;
        cycles(2);
        bus_write(2'd1, 32'h08);
        bus_read(2'd1, rd);
        tests++; if (rd !== 32'h08) begin fails++; $display("FAIL race_setwins: got %h want 08", rd); end
        cycles(1);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL race_irq: got %0b want 1", irq); end
        bus_write(2'd0, 32'h0);
        pulse_intack();
        tests++; if (in_service !== 1'b1) begin fails++; $display("FAIL race_insvc: got %0b want 1", in_service); end
        tests++; if (cur_src !== 3'd0) begin fails++; $display("FAIL race_cur: got %0d want 0", cur_src); end
        bus_read(2'd3, rd);
        tests++; if (rd[8] !== 1'b1) begin fails++; $display("FAIL race_spur: got %0b want 1", rd[8]); end
        bus_read(2'd1, rd);
        tests++; if (rd !== 32'h08) begin fails++; $display("FAIL race_pend_kept: got %h want 08", rd); end
        pulse_rti();
        tests++; if (in_service !== 1'b0) begin fails++; $display("FAIL race_rti: got %0b want 0", in_service); end
        bus_write(2'd1, 32'h08);
        src = 8'h00;
        cycles(3);
    endtask

    task automatic test_sw_trigger();
        bus_write(2'd0, 32'h81);
        bus_write(2'd3, 32'h80);
        cycles(1);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL sw_irq: got %0b want 1", irq); end
        pulse_intack();
        tests++; if (cur_src !== 3'd7) begin fails++; $display("FAIL sw_cur7: got %0d want 7", cur_src); end
        bus_write(2'd3, 32'h01);
        pulse_intack();
        tests++; if (cur_src !== 3'd7) begin fails++; $display("FAIL sw_ignored_cur: got %0d want 7", cur_src); end
        bus_read(2'd1, rd);
        tests++; if (rd !== 32'h01) begin fails++; $display("FAIL sw_ignored_pend: got %h want 01", rd); end
        pulse_rti();
        cycles(1);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL sw_irq2: got %0b want 1", irq); end
        pulse_intack();
        tests++; if (cur_src !== 3'd0) begin fails++; $display("FAIL sw_cur0: got %0d want 0", cur_src); end
        pulse_rti();
        pulse_rti();
        tests++; if (in_service !== 1'b0) begin fails++; $display("FAIL sw_rti_idle: got %0b want 0", in_service); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL sw_rti_idle_irq: got %0b want 0", irq); end
    endtask

    task automatic test_simultaneous();
        bus_write(2'd3, 32'h01);
        cycles(1);
        intack = 1'b1; rti = 1'b1;
        cycles(1);
        tests++; if (in_service !== 1'b1) begin fails++; $display("FAIL sim_idle_take: got %0b want 1", in_service); end
        cycles(1);
        intack = 1'b0; rti = 1'b0;
        tests++; if (in_service !== 1'b0) begin fails++; $display("FAIL sim_svc_rti: got %0b want 0", in_service); end
        bus_write(2'd0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; we = 1'b0; intack = 1'b0; rti = 1'b0;
        addr = '0; data_in = '0; src = '0;
        cycles(2);
        rst = 1'b0;
        cycles(1);
        test_reset();
        test_readback();
        test_edge();
        test_priority();
        test_level();
        test_races();
        test_sw_trigger();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
